// File: rtl/hazard_sequencer.sv
// Pipeline hazard sequencer: detects load-use and branch hazards, and stalls the front end
// while a multi-cycle multiply/divide runs. Also keeps a saturating count of stall cycles.
module hazard_sequencer #(
  parameter logic [5:0]  LW_OP      = 6'h23,
  parameter logic [5:0]  BEQ_OP     = 6'h04,
  parameter int unsigned MD_LATENCY = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [5:0]  ifid_op,
  input  logic [4:0]  ifid_rs,
  input  logic [4:0]  ifid_rt,
  input  logic [5:0]  idex_op,
  input  logic [4:0]  idex_rt,
  input  logic [5:0]  exmem_op,
  input  logic [4:0]  exmem_rt,
  input  logic        branch_taken,
  input  logic        md_start,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        idex_bubble,
  output logic        ifid_flush,
  output logic        md_busy,
  output logic        md_done,
  output logic [15:0] stall_cycles
);

  typedef enum logic [0:0] {StRun, StMdWait} state_e;

  localparam logic [7:0] MdLoad = 8'(MD_LATENCY - 1);

  state_e      r_state, w_state_d;
  logic [7:0]  r_md_cnt, w_md_cnt_d;
  logic        r_md_done, w_md_done_d;
  logic [15:0] r_stall, w_stall_d;

  logic w_idex_match, w_exmem_match;
  logic w_load_use, w_br_dep, w_br_load, w_hazard;

  // Register 0 is hardwired zero, so a match on it is never a real dependency.
  assign w_idex_match  = (idex_rt != 5'd0) && ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
  assign w_exmem_match = (exmem_rt != 5'd0) && ((exmem_rt == ifid_rs) || (exmem_rt == ifid_rt));

  assign w_load_use = (idex_op == LW_OP) && w_idex_match;
  assign w_br_dep   = (ifid_op == BEQ_OP) && w_idex_match;
  assign w_br_load  = (ifid_op == BEQ_OP) && (exmem_op == LW_OP) && w_exmem_match;
  assign w_hazard   = w_load_use || w_br_dep || w_br_load;

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    md_busy     = 1'b0;
    w_state_d   = r_state;
    w_md_cnt_d  = r_md_cnt;
    w_md_done_d = 1'b0;
    unique case (r_state)
      StRun: begin
        pc_write    = !w_hazard;
        ifid_write  = !w_hazard;
        idex_bubble = w_hazard;
        ifid_flush  = branch_taken && !w_hazard;
        if (md_start && !w_hazard) begin
          w_state_d  = StMdWait;
          w_md_cnt_d = MdLoad;
        end
      end
      StMdWait: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
        md_busy     = 1'b1;
        if (r_md_cnt == 8'd0) begin
          w_state_d   = StRun;
          w_md_done_d = 1'b1;
        end else begin
          w_md_cnt_d = r_md_cnt - 8'd1;
        end
      end
    endcase
    w_stall_d = (!pc_write && (r_stall != 16'hFFFF)) ? r_stall + 16'd1 : r_stall;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= StRun;
      r_md_cnt  <= 8'd0;
      r_md_done <= 1'b0;
      r_stall   <= 16'd0;
    end else begin
      r_state   <= w_state_d;
      r_md_cnt  <= w_md_cnt_d;
      r_md_done <= w_md_done_d;
      r_stall   <= w_stall_d;
    end
  end

  assign md_done      = r_md_done;
  assign stall_cycles = r_stall;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench for hazard_sequencer: directed scenarios plus randomized traffic
// compared against a cycle-count reference model.
module tb_hazard_sequencer;

  localparam logic [5:0] LW  = 6'h23;
  localparam logic [5:0] BEQ = 6'h04;
  localparam int         LAT = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  ifid_op, idex_op, exmem_op;
  logic [4:0]  ifid_rs, ifid_rt, idex_rt, exmem_rt;
  logic        branch_taken, md_start;
  logic        pc_write, ifid_write, idex_bubble, ifid_flush, md_busy, md_done;
  logic [15:0] stall_cycles;

  int n_checks = 0;
  int n_errors = 0;

  hazard_sequencer #(.LW_OP(LW), .BEQ_OP(BEQ), .MD_LATENCY(LAT)) dut (
    .clock       (clock),
    .reset       (reset),
    .ifid_op     (ifid_op),
    .ifid_rs     (ifid_rs),
    .ifid_rt     (ifid_rt),
    .idex_op     (idex_op),
    .idex_rt     (idex_rt),
    .exmem_op    (exmem_op),
    .exmem_rt    (exmem_rt),
    .branch_taken(branch_taken),
    .md_start    (md_start),
    .pc_write    (pc_write),
    .ifid_write  (ifid_write),
    .idex_bubble (idex_bubble),
    .ifid_flush  (ifid_flush),
    .md_busy     (md_busy),
    .md_done     (md_done),
    .stall_cycles(stall_cycles)
  );

  always #5 clock = ~clock;

  task automatic clear_inputs();
    ifid_op = 6'h00; ifid_rs = 5'd0; ifid_rt = 5'd0;
    idex_op = 6'h00; idex_rt = 5'd0;
    exmem_op = 6'h00; exmem_rt = 5'd0;
    branch_taken = 1'b0; md_start = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  // Reference hazard: any of the three dependency rules, register 0 never matches.
  function automatic bit ref_hazard(input logic [5:0] f_op, input logic [4:0] f_rs,
                                    input logic [4:0] f_rt, input logic [5:0] d_op,
                                    input logic [4:0] d_rt, input logic [5:0] m_op,
                                    input logic [4:0] m_rt);
    bit uses_d, uses_m;
    uses_d = (d_rt != 0) && (d_rt == f_rs || d_rt == f_rt);
    uses_m = (m_rt != 0) && (m_rt == f_rs || m_rt == f_rt);
    return (d_op == LW && uses_d) || (f_op == BEQ && uses_d) ||
           (f_op == BEQ && m_op == LW && uses_m);
  endfunction

  task automatic test_reset();
    clear_inputs();
    @(negedge clock);
    reset = 1'b1;
    idex_op = LW; idex_rt = 5'd9; ifid_rt = 5'd9;
    #2;
    n_checks++;
    if (stall_cycles !== 16'd0 || md_busy !== 1'b0 || md_done !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_regs: got stall=%0d busy=%b done=%b want 0 0 0",
               stall_cycles, md_busy, md_done);
    end
    n_checks++;
    if (pc_write !== 1'b0 || idex_bubble !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_run_rules: got pc_write=%b bubble=%b want 0 1", pc_write, idex_bubble);
    end
    @(posedge clock);
    #1;
    n_checks++;
    if (stall_cycles !== 16'd0) begin
      n_errors++;
      $display("FAIL reset_hold_stall: got %0d want 0", stall_cycles);
    end
    reset = 1'b0;
    clear_inputs();
  endtask

  task automatic test_load_use();
    do_reset();
    idex_op = LW; idex_rt = 5'd5; ifid_rs = 5'd5;
    @(negedge clock);
    n_checks++;
    if (pc_write !== 1'b0 || ifid_write !== 1'b0 || idex_bubble !== 1'b1) begin
      n_errors++;
      $display("FAIL load_use_stall: got pc=%b ifid_w=%b bubble=%b want 0 0 1",
               pc_write, ifid_write, idex_bubble);
    end
    @(posedge clock);
    #1 idex_rt = 5'd0;
    n_checks++;
    if (stall_cycles !== 16'd1) begin
      n_errors++;
      $display("FAIL load_use_count: got %0d want 1", stall_cycles);
    end
    @(negedge clock);
    n_checks++;
    if (pc_write !== 1'b1 || idex_bubble !== 1'b0) begin
      n_errors++;
      $display("FAIL load_use_r0: got pc=%b bubble=%b want 1 0", pc_write, idex_bubble);
    end
    @(posedge clock);
    #1;
    n_checks++;
    if (stall_cycles !== 16'd1) begin
      n_errors++;
      $display("FAIL load_use_r0_count: got %0d want 1", stall_cycles);
    end
    clear_inputs();
  endtask

  task automatic test_branch();
    do_reset();
    ifid_op = BEQ; exmem_op = LW; exmem_rt = 5'd7; ifid_rt = 5'd7; branch_taken = 1'b1;
    @(negedge clock);
    n_checks++;
    if (pc_write !== 1'b0 || idex_bubble !== 1'b1 || ifid_flush !== 1'b0) begin
      n_errors++;
      $display("FAIL br_load: got pc=%b bubble=%b flush=%b want 0 1 0",
               pc_write, idex_bubble, ifid_flush);
    end
    @(posedge clock);
    #1 exmem_op = 6'h00; idex_rt = 5'd3; ifid_rs = 5'd3;
    @(negedge clock);
    n_checks++;
    if (pc_write !== 1'b0 || ifid_flush !== 1'b0) begin
      n_errors++;
      $display("FAIL br_dep: got pc=%b flush=%b want 0 0", pc_write, ifid_flush);
    end
    @(posedge clock);
    #1 idex_rt = 5'd4;
    @(negedge clock);
    n_checks++;
    if (pc_write !== 1'b1 || ifid_flush !== 1'b1) begin
      n_errors++;
      $display("FAIL br_flush: got pc=%b flush=%b want 1 1", pc_write, ifid_flush);
    end
    @(posedge clock);
    #1;
    n_checks++;
    if (stall_cycles !== 16'd2) begin
      n_errors++;
      $display("FAIL br_count: got %0d want 2", stall_cycles);
    end
    clear_inputs();
  endtask

  task automatic test_md();
    do_reset();
    // Issue under a hazard must be dropped.
    md_start = 1'b1; idex_op = LW; idex_rt = 5'd2; ifid_rt = 5'd2;
    @(posedge clock);
    #1 idex_op = 6'h00;
    n_checks++;
    if (md_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL md_hazard_ignored: got busy=%b want 0", md_busy);
    end
    @(posedge clock);
    #1 md_start = 1'b0; branch_taken = 1'b1;
    for (int i = 0; i < LAT; i++) begin
      if (i == 3) md_start = 1'b1;
      @(negedge clock);
      n_checks++;
      if (md_busy !== 1'b1 || pc_write !== 1'b0 || idex_bubble !== 1'b1 ||
          ifid_flush !== 1'b0 || md_done !== 1'b0) begin
        n_errors++;
        $display("FAIL md_wait_%0d: got busy=%b pc=%b bubble=%b flush=%b done=%b want 1 0 1 0 0",
                 i, md_busy, pc_write, idex_bubble, ifid_flush, md_done);
      end
      @(posedge clock);
      #1;
    end
    md_start = 1'b0; branch_taken = 1'b0;
    n_checks++;
    if (md_busy !== 1'b0 || md_done !== 1'b1 || stall_cycles !== 16'd9) begin
      n_errors++;
      $display("FAIL md_exit: got busy=%b done=%b stall=%0d want 0 1 9",
               md_busy, md_done, stall_cycles);
    end
    @(posedge clock);
    #1;
    n_checks++;
    if (md_done !== 1'b0 || md_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL md_done_pulse: got done=%b busy=%b want 0 0", md_done, md_busy);
    end
  endtask

  task automatic test_md_reset();
    do_reset();
    md_start = 1'b1;
    @(posedge clock);
    #1 md_start = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    n_checks++;
    if (md_busy !== 1'b1) begin
      n_errors++;
      $display("FAIL md_rst_busy: got %b want 1", md_busy);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (md_busy !== 1'b0 || md_done !== 1'b0 || stall_cycles !== 16'd0 || pc_write !== 1'b1) begin
      n_errors++;
      $display("FAIL md_rst_abort: got busy=%b done=%b stall=%0d pc=%b want 0 0 0 1",
               md_busy, md_done, stall_cycles, pc_write);
    end
    @(posedge clock);
    #1 reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      n_checks++;
      if (md_done !== 1'b0 || md_busy !== 1'b0) begin
        n_errors++;
        $display("FAIL md_rst_no_done_%0d: got done=%b busy=%b want 0 0", i, md_done, md_busy);
      end
    end
  endtask

  task automatic test_random();
    int  wait_left = 0;   // MD_WAIT cycles still to spend, including the current one
    bit  done_exp = 0;
    int  stall_exp = 0;
    bit  hz, e_pc, e_bub, e_flush, e_busy;
    logic [5:0] ops [3];
    ops[0] = LW; ops[1] = BEQ; ops[2] = 6'h00;
    do_reset();
    for (int c = 0; c < 500; c++) begin
      ifid_op  = ops[$urandom_range(2)];
      idex_op  = ops[$urandom_range(2)];
      exmem_op = ops[$urandom_range(2)];
      ifid_rs  = 5'($urandom_range(3));
      ifid_rt  = 5'($urandom_range(3));
      idex_rt  = 5'($urandom_range(3));
      exmem_rt = 5'($urandom_range(3));
      branch_taken = 1'($urandom_range(1));
      md_start = ($urandom_range(7) == 0);
      hz = ref_hazard(ifid_op, ifid_rs, ifid_rt, idex_op, idex_rt, exmem_op, exmem_rt);
      e_busy  = (wait_left > 0);
      e_pc    = !e_busy && !hz;
      e_bub   = e_busy || hz;
      e_flush = !e_busy && !hz && branch_taken;
      @(negedge clock);
      n_checks++;
      if (pc_write !== e_pc || ifid_write !== e_pc || idex_bubble !== e_bub ||
          ifid_flush !== e_flush || md_busy !== e_busy || md_done !== done_exp ||
          stall_cycles !== 16'(stall_exp)) begin
        n_errors++;
        $display("FAIL random_%0d: got pc=%b ifw=%b bub=%b fl=%b busy=%b done=%b st=%0d want %b %b %b %b %b %b %0d",
                 c, pc_write, ifid_write, idex_bubble, ifid_flush, md_busy, md_done,
                 stall_cycles, e_pc, e_pc, e_bub, e_flush, e_busy, done_exp, stall_exp);
      end
      if (!e_pc && stall_exp < 65535) stall_exp++;
      if (e_busy) begin
        done_exp  = (wait_left == 1);
        wait_left = wait_left - 1;
      end else begin
        done_exp = 0;
        if (md_start && !hz) wait_left = LAT;
      end
      @(posedge clock);
      #1;
    end
    clear_inputs();
  endtask

  task automatic test_saturation();
    do_reset();
    idex_op = LW; idex_rt = 5'd6; ifid_rs = 5'd6;
    repeat (65534) @(posedge clock);
    #1;
    n_checks++;
    if (stall_cycles !== 16'hFFFE) begin
      n_errors++;
      $display("FAIL sat_edge: got %h want fffe", stall_cycles);
    end
    repeat (70000 - 65534) @(posedge clock);
    #1;
    n_checks++;
    if (stall_cycles !== 16'hFFFF) begin
      n_errors++;
      $display("FAIL sat_hold: got %h want ffff", stall_cycles);
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_load_use();
    test_branch();
    test_md();
    test_md_reset();
    test_random();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hazard_sequencer.md
HAZARD_SEQUENCER -- requirements
Module: hazard_sequencer

Interface
REQ-001 Parameter LW_OP, default 6'h23, load-word opcode.
REQ-002 Parameter BEQ_OP, default 6'h04, branch-equal opcode.
REQ-003 Parameter MD_LATENCY, default 8, multiply/divide execution cycles; legal range 2..255.
REQ-004 clock  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 ifid_op  input  6  opcode in IF/ID.
REQ-007 ifid_rs  input  5  rs field in IF/ID.
REQ-008 ifid_rt  input  5  rt field in IF/ID.
REQ-009 idex_op  input  6  opcode in ID/EX.
REQ-010 idex_rt  input  5  destination rt in ID/EX.
REQ-011 exmem_op  input  6  opcode in EX/MEM.
REQ-012 exmem_rt  input  5  destination rt in EX/MEM.
REQ-013 branch_taken  input  1  branch resolved taken this cycle.
REQ-014 md_start  input  1  mult/div issued into EX this cycle.
REQ-015 pc_write  output  1  PC update enable.
REQ-016 ifid_write  output  1  IF/ID register write enable.
REQ-017 idex_bubble  output  1  load NOP into ID/EX.
REQ-018 ifid_flush  output  1  clear IF/ID to NOP.
REQ-019 md_busy  output  1  high while in MD_WAIT.
REQ-020 md_done  output  1  one-cycle registered pulse when mult/div completes.
REQ-021 stall_cycles  output  16  saturating count of cycles with pc_write=0.

Function
REQ-022 hazard SHALL be the OR of load_use, br_dep and br_load, all combinational and each false when the matched register is 0.
REQ-023 load_use SHALL be idex_op==LW_OP and idex_rt equal to ifid_rs or ifid_rt.
REQ-024 br_dep SHALL be ifid_op==BEQ_OP and idex_rt equal to ifid_rs or ifid_rt.
REQ-025 br_load SHALL be ifid_op==BEQ_OP, exmem_op==LW_OP, and exmem_rt equal to ifid_rs or ifid_rt.
REQ-026 State machine SHALL have two states: RUN and MD_WAIT, plus an 8-bit down-counter md_cnt.
REQ-027 In RUN, pc_write=ifid_write=!hazard, idex_bubble=hazard, ifid_flush=branch_taken & !hazard, all same-cycle.
REQ-028 In RUN, md_start & !hazard SHALL load md_cnt=MD_LATENCY-1 and go to MD_WAIT next edge.
REQ-029 In RUN, md_start & hazard SHALL be ignored; the issuer re-asserts md_start once the hazard clears.
REQ-030 In MD_WAIT, pc_write=ifid_write=0, idex_bubble=1, ifid_flush=0, md_busy=1, regardless of other inputs.
REQ-031 In MD_WAIT, md_cnt SHALL decrement each edge; at md_cnt==0 the next edge returns to RUN and sets md_done=1 for exactly one cycle.
REQ-032 md_start and branch_taken in MD_WAIT SHALL be ignored.
REQ-033 Total MD_WAIT residency SHALL be exactly MD_LATENCY cycles.
REQ-034 stall_cycles SHALL increment on every edge where pc_write==0 and hold at 16'hFFFF.
REQ-035 Hazards SHALL be re-evaluated every cycle; consecutive hazard cycles produce consecutive stalls.

Reset
REQ-036 reset=1 SHALL immediately force state=RUN, md_cnt=0, md_done=0, stall_cycles=0, independent of clock.
REQ-037 During and after reset, the combinational outputs SHALL follow the RUN rules.
REQ-038 Reset asserted in MD_WAIT SHALL abort the operation with no md_done pulse.

Verification
REQ-039 idex_op=6'h23, idex_rt=5, ifid_rs=5 for one cycle -> pc_write=0, idex_bubble=1 that cycle, stall_cycles=1 after the edge.
REQ-040 Same stimulus with idex_rt=0 -> pc_write=1, idex_bubble=0, stall_cycles unchanged.
REQ-041 ifid_op=6'h04, exmem_op=6'h23, exmem_rt=7, ifid_rt=7 -> stall; with branch_taken=1 the same cycle, ifid_flush=0.
REQ-042 md_start=1 with no hazard, MD_LATENCY=8 -> md_busy high for 8 cycles, md_done pulses one cycle on return to RUN, stall_cycles +8.
REQ-043 reset pulsed on the 3rd MD_WAIT cycle -> md_busy=0 immediately, no md_done, stall_cycles=0.
REQ-044 Hazard forced continuously for 70000 cycles -> stall_cycles saturates at 16'hFFFF.
